// File: rtl/config_manager_uc_pkg.sv
// Shared types for the configuration-load control unit: state encodings and word indexing.
package config_manager_uc_pkg;

    localparam int IDX_W     = 3;
    localparam int NUM_WORDS = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        ESPERA_DADO   = 4'd1,
        CARREGA       = 4'd2,
        FIM           = 4'd3,
        ERRO_PARIDADE = 4'd4,
        ERRO_TIMEOUT  = 4'd5
    } state_t;

endpackage

// File: rtl/config_manager_uc_contador_timeout.sv
// Saturating up-counter with synchronous clear; terminal is high while the count sits at MODULO-1.
// Clear wins over enable; the count never wraps.
module config_manager_uc_contador_timeout #(
    parameter int MODULO = 100,
    localparam int W = (MODULO > 1) ? $clog2(MODULO) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [W-1:0] MAX_COUNT = W'(MODULO - 1);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX_COUNT)) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == MAX_COUNT);

endmodule

// File: rtl/config_manager_uc.sv
// Sequences the eight config-limit register loads from received words, with start handshake,
// inter-word timeout and sticky parity/timeout error flags. Strobe follows a good word by one cycle.
module config_manager_uc
    import config_manager_uc_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fim_recepcao_config,
    input  logic       parity_config_ok,
    output logic       load_temp1,
    output logic       load_temp2,
    output logic       load_temp3,
    output logic       load_temp4,
    output logic       load_temp5,
    output logic       load_temp6,
    output logic       load_temp7,
    output logic       load_lim_um,
    output logic       configurando,
    output logic       pronto,
    output logic       erro_paridade,
    output logic       erro_timeout,
    output logic [3:0] db_estado,
    output logic [2:0] db_indice
);

    state_t               estado;
    logic [IDX_W-1:0]     indice;
    logic                 timer_clear;
    logic                 timer_enable;
    logic                 timer_expired;
    logic [NUM_WORDS-1:0] load_vec;

    // Timer restarts on each accepted start and after every load, so it measures the gap between words.
    assign timer_clear  = ((estado == INICIAL) && iniciar) || (estado == CARREGA);
    assign timer_enable = (estado == ESPERA_DADO);

    config_manager_uc_contador_timeout #(
        .MODULO (TIMEOUT_CICLOS)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .terminal (timer_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= INICIAL;
            indice        <= '0;
            erro_paridade <= 1'b0;
            erro_timeout  <= 1'b0;
        end else begin
            case (estado)
                INICIAL: begin
                    if (iniciar) begin
                        erro_paridade <= 1'b0;
                        erro_timeout  <= 1'b0;
                        indice        <= '0;
                        estado        <= ESPERA_DADO;
                    end
                end
                ESPERA_DADO: begin
                    // A word arriving on the expiry cycle is still accepted.
                    if (fim_recepcao_config) begin
                        if (parity_config_ok) begin
                            estado <= CARREGA;
                        end else begin
                            erro_paridade <= 1'b1;
                            estado        <= ERRO_PARIDADE;
                        end
                    end else if (timer_expired) begin
                        erro_timeout <= 1'b1;
                        estado       <= ERRO_TIMEOUT;
                    end
                end
                CARREGA: begin
                    if (indice == LAST_IDX) begin
                        estado <= FIM;
                    end else begin
                        indice <= indice + 1'b1;
                        estado <= ESPERA_DADO;
                    end
                end
                FIM:           estado <= INICIAL;
                ERRO_PARIDADE: estado <= INICIAL;
                ERRO_TIMEOUT:  estado <= INICIAL;
                default:       estado <= INICIAL;
            endcase
        end
    end

    always_comb begin
        load_vec = '0;
        if (estado == CARREGA) begin
            load_vec[indice] = 1'b1;
        end
    end

    assign load_temp1   = load_vec[0];
    assign load_temp2   = load_vec[1];
    assign load_temp3   = load_vec[2];
    assign load_temp4   = load_vec[3];
    assign load_temp5   = load_vec[4];
    assign load_temp6   = load_vec[5];
    assign load_temp7   = load_vec[6];
    assign load_lim_um  = load_vec[7];

    assign configurando = (estado == ESPERA_DADO) || (estado == CARREGA);
    assign pronto       = (estado == FIM);
    assign db_estado    = estado;
    assign db_indice    = indice;

endmodule
